// File: rtl/board_io_controller.sv
`default_nettype none
// ============================================================================
//  Module      : board_io_controller
//  Description : Board-side IO for the memory-mapped IO window. Switches and
//                buttons are synchronised and debounced onto io_input_bus.
//                io_output_bus is registered and drives LEDs and six
//                seven-segment displays.
//  Revision    : 1.0 - initial release
// ============================================================================
module board_io_controller #(
    parameter int SW_WIDTH          = 10,
    parameter int KEY_WIDTH         = 4,
    parameter int DEBOUNCE_CYCLES   = 50000,
    parameter int IO_INPUT_BUS_LEN  = 14,
    parameter int IO_OUTPUT_BUS_LEN = 52,
    parameter int HEX_ACTIVE_LOW    = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [SW_WIDTH-1:0]          SW,
    input  logic [KEY_WIDTH-1:0]         KEY,
    input  logic [IO_OUTPUT_BUS_LEN-1:0] io_output_bus,
    output logic [IO_INPUT_BUS_LEN-1:0]  io_input_bus,
    output logic [9:0]                   LEDR,
    output logic [6:0]                   HEX0,
    output logic [6:0]                   HEX1,
    output logic [6:0]                   HEX2,
    output logic [6:0]                   HEX3,
    output logic [6:0]                   HEX4,
    output logic [6:0]                   HEX5
);

    localparam int c_NBITS = SW_WIDTH + KEY_WIDTH;
    // One extra bit so DEBOUNCE_CYCLES-1 always fits, even for 1.
    localparam int c_CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    // Idle pin levels: switches off (0), buttons released (1).
    localparam logic [c_NBITS-1:0] c_IDLE = {{KEY_WIDTH{1'b1}}, {SW_WIDTH{1'b0}}};
    localparam logic [6:0] c_HEX_XOR = (HEX_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    logic [c_NBITS-1:0]           r_sync1;
    logic [c_NBITS-1:0]           r_sync2;
    logic [c_NBITS-1:0]           w_stable;
    logic [IO_OUTPUT_BUS_LEN-1:0] r_out;

    // Two-flop synchroniser for all raw pins, reset to idle levels.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= c_IDLE;
            r_sync2 <= c_IDLE;
        end else begin
            r_sync1 <= {KEY, SW};
            r_sync2 <= r_sync1;
        end
    end

    generate
        for (genvar gi = 0; gi < c_NBITS; gi++) begin : g_debounce
            logic [c_CNT_W-1:0] r_cnt;
            logic               r_stable;

            // Accept a new level only after DEBOUNCE_CYCLES consecutive disagreements.
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_cnt    <= '0;
                    r_stable <= c_IDLE[gi];
                end else if (r_sync2[gi] == r_stable) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_CNT_MAX) begin
                    r_stable <= r_sync2[gi];
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end

            assign w_stable[gi] = r_stable;
        end
    endgenerate

    // Buttons are active-low on the board; the core sees 1 = pressed.
    assign io_input_bus = {~w_stable[c_NBITS-1:SW_WIDTH], w_stable[SW_WIDTH-1:0]};

    // Output image captured every cycle; cleared to all-off on reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out <= '0;
        end else begin
            r_out <= io_output_bus;
        end
    end

    assign LEDR = r_out[9:0];
    assign HEX0 = r_out[16:10] ^ c_HEX_XOR;
    assign HEX1 = r_out[23:17] ^ c_HEX_XOR;
    assign HEX2 = r_out[30:24] ^ c_HEX_XOR;
    assign HEX3 = r_out[37:31] ^ c_HEX_XOR;
    assign HEX4 = r_out[44:38] ^ c_HEX_XOR;
    assign HEX5 = r_out[51:45] ^ c_HEX_XOR;

endmodule
`default_nettype wire

// File: tb/tb_board_io_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_board_io_controller
//  Description : Self-checking bench for board_io_controller with a
//                window-based behavioural model and directed literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_board_io_controller;

    localparam int D = 4;
    localparam logic [13:0] c_IDLE = 14'h3C00;

    logic        clock = 1'b0;
    logic        reset;
    logic [9:0]  SW;
    logic [3:0]  KEY;
    logic [51:0] io_output_bus;
    logic [13:0] io_input_bus;
    logic [9:0]  LEDR;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [6:0]  hex_pins [6];

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clock = ~clock;

    board_io_controller #(
        .SW_WIDTH(10), .KEY_WIDTH(4), .DEBOUNCE_CYCLES(D),
        .IO_INPUT_BUS_LEN(14), .IO_OUTPUT_BUS_LEN(52), .HEX_ACTIVE_LOW(1)
    ) dut (
        .clock(clock), .reset(reset), .SW(SW), .KEY(KEY),
        .io_output_bus(io_output_bus), .io_input_bus(io_input_bus),
        .LEDR(LEDR), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2),
        .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
    );

    always_comb begin
        hex_pins[0] = HEX0; hex_pins[1] = HEX1; hex_pins[2] = HEX2;
        hex_pins[3] = HEX3; hex_pins[4] = HEX4; hex_pins[5] = HEX5;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the debouncer sees raw pins two edges late; a bit takes
    // a new level once the last D delayed samples all show that level.
    logic [13:0] m_p1, m_p2, m_stable;
    logic [13:0] m_win [D];
    logic [13:0] m_all1, m_all0;
    logic [51:0] m_out;

    always @(posedge clock) begin
        if (reset) begin
            m_p1 = c_IDLE; m_p2 = c_IDLE; m_stable = c_IDLE; m_out = '0;
            for (int i = 0; i < D; i++) m_win[i] = c_IDLE;
        end else begin
            for (int i = D - 1; i > 0; i--) m_win[i] = m_win[i-1];
            m_win[0] = m_p2;
            m_all1 = '1; m_all0 = '1;
            for (int i = 0; i < D; i++) begin
                m_all1 = m_all1 & m_win[i];
                m_all0 = m_all0 & ~m_win[i];
            end
            m_stable = m_all1 | (m_stable & ~m_all0);
            m_p2 = m_p1;
            m_p1 = {KEY, SW};
            m_out = io_output_bus;
        end
    end

    // Every-cycle comparison against the model.
    always @(posedge clock) begin
        #1;
        if (chk_en) begin
            check("model_in_bus", io_input_bus, {~m_stable[13:10], m_stable[9:0]});
            check("model_ledr", LEDR, m_out[9:0]);
            for (int n = 0; n < 6; n++)
                check("model_hex", hex_pins[n], m_out[10+7*n +: 7] ^ 7'h7F);
        end
    end

    task automatic edge_chk;
        @(posedge clock); #1;
    endtask

    logic [51:0] ob;

    initial begin
        reset = 1'b1; SW = '0; KEY = 4'hF; io_output_bus = '0;
        edge_chk();
        edge_chk();
        check("rst_in_bus", io_input_bus, 14'h0000);
        check("rst_ledr", LEDR, 10'h000);
        for (int n = 0; n < 6; n++) check("rst_hex", hex_pins[n], 7'h7F);
        @(negedge clock); reset = 1'b0; chk_en = 1'b1;

        // Switch change held: visible on exactly the 6th edge.
        SW = 10'h2A5;
        for (int k = 1; k <= 6; k++) begin
            edge_chk();
            check("sw_latency", io_input_bus[9:0], (k == 6) ? 10'h2A5 : 10'h000);
        end

        // Three-cycle KEY[2] glitch is rejected.
        for (int i = 0; i < 13; i++) begin
            @(negedge clock); KEY[2] = (i < 3) ? 1'b0 : 1'b1;
            edge_chk();
            check("key2_glitch", io_input_bus[12], 1'b0);
        end

        // KEY[0] press then release, 6 edges each way.
        @(negedge clock); KEY[0] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            edge_chk();
            check("key0_press", io_input_bus[10], (k == 6));
        end
        @(negedge clock); KEY[0] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            edge_chk();
            check("key0_release", io_input_bus[10], (k < 6));
        end

        // Output path mapping with one-cycle latency.
        ob = '0; ob[9:0] = 10'h3FF; ob[16:10] = 7'h3F; ob[51:45] = 7'h06;
        @(negedge clock); io_output_bus = ob;
        edge_chk();
        check("out_ledr", LEDR, 10'h3FF);
        check("out_hex0", HEX0, 7'h40);
        check("out_hex5", HEX5, 7'h79);
        check("out_hex1", HEX1, 7'h7F);

        // Reset mid-count discards the partial change.
        @(negedge clock); SW = '0;
        repeat (10) @(negedge clock);
        SW = 10'h001;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        edge_chk();
        check("midrst_ledr", LEDR, 10'h000);
        check("midrst_hex0", HEX0, 7'h7F);
        @(negedge clock); reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            edge_chk();
            check("midrst_sw0", io_input_bus[0], (k == 6));
        end

        // Randomised stimulus checked by the model.
        for (int c = 0; c < 600; c++) begin
            @(negedge clock);
            reset = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 4) == 0) begin
                int b;
                b = $urandom_range(0, 13);
                if (b < 10) SW[b] = ~SW[b];
                else KEY[b-10] = ~KEY[b-10];
            end
            io_output_bus = {$urandom, $urandom};
        end
        @(negedge clock); reset = 1'b0;
        repeat (10) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
